cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: five single-entry holding slots feed one registered
// broadcast port, chosen round-robin. A word waits at least one edge in its slot
// before it can be broadcast. A slot that is granted can take a new word on the
// same edge, so one requester can stream with no gaps.
module cdb_arbiter #(
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [4:0]                          req_valid,
   input  logic [5*(TAG_W+DATA_W)-1:0]         req_bus,
   output logic [4:0]                          req_ready,
   input  logic                                flush,
   output logic                                cdb_valid,
   output logic [TAG_W+DATA_W-1:0]             cdb_bus,
   output logic [2:0]                          cdb_src
);

   localparam int unsigned W      = TAG_W + DATA_W;
   localparam int unsigned NumReq = 5;

   // Holding slots and their occupied flags
   logic [W-1:0]        slot_q [NumReq];
   logic [W-1:0]        slot_d [NumReq];
   logic [NumReq-1:0]   occ_q, occ_d;

   // Index of the last granted slot; the search starts one past it
   logic [2:0]          rr_ptr_q, rr_ptr_d;

   // Registered broadcast outputs
   logic                cdb_valid_q, cdb_valid_d;
   logic [W-1:0]        cdb_bus_q, cdb_bus_d;
   logic [2:0]          cdb_src_q, cdb_src_d;

   // Grant selection
   logic                gnt_vld;
   logic [2:0]          gnt_idx;
   logic [NumReq-1:0]   gnt_oh;
   logic [3:0]          cand;

   // Round-robin search over occupied slots, starting after rr_ptr and wrapping 4 -> 0
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 3'd0;
      cand    = 4'd0;
      for (int unsigned k = 1; k <= NumReq; k++) begin
         cand = {1'b0, rr_ptr_q} + 4'(k);
         if (cand >= 4'(NumReq)) begin
            cand = cand - 4'(NumReq);
         end
         if (!gnt_vld && occ_q[cand[2:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[2:0];
         end
      end
   end

   // One-hot form of the grant, used by the ready path
   always_comb begin
      gnt_oh = '0;
      if (gnt_vld) begin
         gnt_oh[gnt_idx] = 1'b1;
      end
   end

   // A slot is ready when empty or being drained this cycle; flush blocks all capture
   always_comb begin
      if (flush) begin
         req_ready = '0;
      end else begin
         req_ready = ~occ_q | gnt_oh;
      end
   end

   // Next-state: flush wins; otherwise broadcast the grant, then capture new words
   always_comb begin
      occ_d       = occ_q;
      slot_d      = slot_q;
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_bus_d   = cdb_bus_q;
      cdb_src_d   = cdb_src_q;

      if (flush) begin
         occ_d = '0;
      end else begin
         if (gnt_vld) begin
            cdb_valid_d    = 1'b1;
            cdb_bus_d      = slot_q[gnt_idx];
            cdb_src_d      = gnt_idx;
            rr_ptr_d       = gnt_idx;
            occ_d[gnt_idx] = 1'b0;
         end
         // Capture after the clear so a granted slot can reload on the same edge
         for (int unsigned i = 0; i < NumReq; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               occ_d[i]  = 1'b1;
               slot_d[i] = req_bus[W*i +: W];
            end
         end
      end
   end

   // State registers; rr_ptr resets to 4 so A0 is first in line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q       <= '0;
         rr_ptr_q    <= 3'd4;
         cdb_valid_q <= 1'b0;
         cdb_bus_q   <= '0;
         cdb_src_q   <= 3'd0;
         for (int unsigned i = 0; i < NumReq; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         occ_q       <= occ_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_bus_q   <= cdb_bus_d;
         cdb_src_q   <= cdb_src_d;
         for (int unsigned i = 0; i < NumReq; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_bus   = cdb_bus_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run checked
// against a slot-level behavioural model.
module tb_cdb_arbiter;

   localparam int W = 12;
   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [4:0]     req_valid;
   logic [N*W-1:0] req_bus;
   logic [4:0]     req_ready;
   logic           flush;
   logic           cdb_valid;
   logic [W-1:0]   cdb_bus;
   logic [2:0]     cdb_src;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   bit           m_occ  [N];
   logic [W-1:0] m_word [N];
   int           m_rr;
   bit           m_cv;
   logic [W-1:0] m_cb;
   logic [2:0]   m_cs;

   cdb_arbiter #(.TAG_W(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_bus   (req_bus),
      .req_ready (req_ready),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_bus   (cdb_bus),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_occ[i]  = 1'b0;
         m_word[i] = '0;
      end
      m_rr = 4;
      m_cv = 1'b0;
      m_cb = '0;
      m_cs = 3'd0;
   endtask

   // First occupied slot after the last winner, or -1
   function automatic int m_grant();
      for (int k = 1; k <= N; k++) begin
         if (m_occ[(m_rr + k) % N]) return (m_rr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [4:0] m_ready(input logic f);
      logic [4:0] r;
      int g;
      r = '0;
      if (f) return r;
      g = m_grant();
      for (int i = 0; i < N; i++) r[i] = !m_occ[i] || (i == g);
      return r;
   endfunction

   task automatic m_tick(input logic [4:0] v, input logic [N*W-1:0] b, input logic f);
      int g;
      logic [4:0] r;
      if (f) begin
         for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
         m_cv = 1'b0;
         return;
      end
      g = m_grant();
      r = m_ready(1'b0);
      if (g >= 0) begin
         m_cv     = 1'b1;
         m_cb     = m_word[g];
         m_cs     = 3'(g);
         m_rr     = g;
         m_occ[g] = 1'b0;
      end else begin
         m_cv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && r[i]) begin
            m_occ[i]  = 1'b1;
            m_word[i] = b[W*i +: W];
         end
      end
   endtask

   // Reset the DUT and model; returns at a falling edge with rst_n high
   task automatic do_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_bus   = '0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 5'b11111;
      req_bus   = {$urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid);
      end
      n_cmp++;
      if (cdb_bus !== 12'h000) begin
         n_fail++; $display("FAIL reset_bus: got %h want 000", cdb_bus);
      end
      n_cmp++;
      if (cdb_src !== 3'd0) begin
         n_fail++; $display("FAIL reset_src: got %0d want 0", cdb_src);
      end
      n_cmp++;
      if (req_ready !== 5'b11111) begin
         n_fail++; $display("FAIL reset_ready: got %b want 11111", req_ready);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_valid: cycle %0d got %b want 0", c, cdb_valid);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid          = 5'b00010;
      req_bus[W*1 +: W]  = 12'h12A;
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_arrival_valid: got %b want 0", cdb_valid);
      end
      req_valid = '0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h12A, 3'd1}) begin
         n_fail++;
         $display("FAIL single_bcast: got v=%b bus=%h src=%0d want v=1 bus=12a src=1",
                  cdb_valid, cdb_bus, cdb_src);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_after_valid: got %b want 0", cdb_valid);
      end
   endtask

   task automatic test_burst();
      logic [W-1:0] exp_w [N];
      logic [4:0]   exp_r;
      do_reset();
      for (int i = 0; i < N; i++) begin
         exp_w[i] = {4'(i), 8'($urandom)};
         req_bus[W*i +: W] = exp_w[i];
      end
      req_valid = 5'b11111;
      @(posedge clk);
      #1;
      req_valid = '0;
      for (int g = 0; g < N; g++) begin
         @(negedge clk);
         exp_r = 5'((1 << (g + 1)) - 1);
         n_cmp++;
         if (req_ready !== exp_r) begin
            n_fail++; $display("FAIL burst_ready: slot %0d got %b want %b", g, req_ready, exp_r);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, exp_w[g], 3'(g)}) begin
            n_fail++;
            $display("FAIL burst_bcast: got v=%b bus=%h src=%0d want v=1 bus=%h src=%0d",
                     cdb_valid, cdb_bus, cdb_src, exp_w[g], g);
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL burst_end_valid: got %b want 0", cdb_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req_valid         = 5'b10000;
      req_bus[W*4 +: W] = 12'h4C3;
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_src} !== {1'b1, 3'd4}) begin
         n_fail++; $display("FAIL wrap_fetch: got v=%b src=%0d want v=1 src=4", cdb_valid, cdb_src);
      end
      req_valid         = 5'b01001;
      req_bus[W*0 +: W] = 12'h0A5;
      req_bus[W*3 +: W] = 12'h3B7;
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h0A5, 3'd0}) begin
         n_fail++;
         $display("FAIL wrap_first: got v=%b bus=%h src=%0d want v=1 bus=0a5 src=0",
                  cdb_valid, cdb_bus, cdb_src);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h3B7, 3'd3}) begin
         n_fail++;
         $display("FAIL wrap_second: got v=%b bus=%h src=%0d want v=1 bus=3b7 src=3",
                  cdb_valid, cdb_bus, cdb_src);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_valid         = 5'b00100;
      req_bus[W*2 +: W] = 12'h2A1;
      @(posedge clk);
      #1;
      req_bus[W*2 +: W] = 12'h2A2;
      @(negedge clk);
      n_cmp++;
      if (req_ready[2] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_reload_ready: got %b want 1", req_ready[2]);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h2A1, 3'd2}) begin
         n_fail++;
         $display("FAIL b2b_first: got v=%b bus=%h src=%0d want v=1 bus=2a1 src=2",
                  cdb_valid, cdb_bus, cdb_src);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h2A2, 3'd2}) begin
         n_fail++;
         $display("FAIL b2b_second: got v=%b bus=%h src=%0d want v=1 bus=2a2 src=2",
                  cdb_valid, cdb_bus, cdb_src);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_no_dup: got %b want 0", cdb_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      req_valid         = 5'b11101;
      req_bus[W*0 +: W] = 12'h011;
      req_bus[W*2 +: W] = 12'h233;
      req_bus[W*3 +: W] = 12'h344;
      req_bus[W*4 +: W] = 12'h455;
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_src} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL flush_pre: got v=%b src=%0d want v=1 src=0", cdb_valid, cdb_src);
      end
      // Three slots still occupied here
      flush     = 1'b1;
      req_valid = 5'b11111;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 5'b00000) begin
         n_fail++; $display("FAIL flush_ready_low: got %b want 00000", req_ready);
      end
      @(posedge clk);
      #1;
      flush     = 1'b0;
      req_valid = '0;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_valid: got %b want 0", cdb_valid);
      end
      #1;
      n_cmp++;
      if (req_ready !== 5'b11111) begin
         n_fail++; $display("FAIL flush_ready_after: got %b want 11111", req_ready);
      end
      // rr_ptr must still point at A0, so A1 beats A0 next
      req_valid         = 5'b00011;
      req_bus[W*0 +: W] = 12'h0EE;
      req_bus[W*1 +: W] = 12'h1DD;
      @(posedge clk);
      #1;
      req_valid = '0;
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_no_stale: got %b want 0", cdb_valid);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h1DD, 3'd1}) begin
         n_fail++;
         $display("FAIL flush_rr_kept: got v=%b bus=%h src=%0d want v=1 bus=1dd src=1",
                  cdb_valid, cdb_bus, cdb_src);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b1, 12'h0EE, 3'd0}) begin
         n_fail++;
         $display("FAIL flush_rr_next: got v=%b bus=%h src=%0d want v=1 bus=0ee src=0",
                  cdb_valid, cdb_bus, cdb_src);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < N; i++) req_bus[W*i +: W] = {4'(i), 8'($urandom)};
      req_valid = 5'b11111;
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cdb_valid, cdb_bus, cdb_src} !== {1'b0, 12'h000, 3'd0}) begin
         n_fail++;
         $display("FAIL async_reset_out: got v=%b bus=%h src=%0d want v=0 bus=000 src=0",
                  cdb_valid, cdb_bus, cdb_src);
      end
      n_cmp++;
      if (req_ready !== 5'b11111) begin
         n_fail++; $display("FAIL async_reset_ready: got %b want 11111", req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_stale: cycle %0d got %b want 0", c, cdb_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]     v;
      logic [N*W-1:0] b;
      logic           f;
      logic [4:0]     exp_r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
         b = {$urandom, $urandom};
         f = ($urandom_range(0, 19) == 0);
         req_valid = v;
         req_bus   = b;
         flush     = f;
         #1;
         exp_r = m_ready(f);
         n_cmp++;
         if (req_ready !== exp_r) begin
            n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, req_ready, exp_r);
         end
         @(posedge clk);
         m_tick(v, b, f);
         #1;
         n_cmp++;
         if ({cdb_valid, cdb_bus, cdb_src} !== {m_cv, m_cb, m_cs}) begin
            n_fail++;
            $display("FAIL rand_cdb: cycle %0d got v=%b bus=%h src=%0d want v=%b bus=%h src=%0d",
                     c, cdb_valid, cdb_bus, cdb_src, m_cv, m_cb, m_cs);
         end
         @(negedge clk);
      end
      req_valid = '0;
      flush     = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_bus   = '0;
      m_reset();
      test_reset();
      test_single();
      test_burst();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
